pid_vel_integrator: RTL and testbench

Parametrised velocity-form output stage for the BLDC speed loop. It accepts one signed velocity increment or sample per handshake. It produces a registered motor velocity command, using one of several modes: accumulate, difference, hold or passthrough. The result is slew-rate limited and then saturated. It sits between the PID error path and the PWM commutation/duty logic.

---
 rtl/pid_vel_integrator.sv | 171 +++++++++++++++++
 tb/tb_pid_vel_integrator.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_vel_integrator.sv
// Velocity-form output stage for the BLDC speed loop: accumulate/difference/hold/passthrough,
// then slew limiting, then saturation. One sample per three cycles (IDLE -> CALC -> LIMIT).
module pid_vel_integrator #(
   parameter int W        = 9,
   parameter int OUT_MAX  = 2**(W-1) - 1,
   parameter int OUT_MIN  = -(2**(W-1) - 1),
   parameter int SLEW_MAX = 0
) (
   input  logic                CLK,
   input  logic                RSTN,
   input  logic signed [W-1:0] in_vel,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          mode,
   input  logic                clear,
   output logic signed [W-1:0] out_vel,
   output logic                out_valid,
   output logic                sat_hi,
   output logic                sat_lo,
   output logic                slew_lim
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CALC  = 2'd1;
   localparam logic [1:0] LIMIT = 2'd2;

   localparam logic [1:0] MODE_ACC  = 2'd0;
   localparam logic [1:0] MODE_DIFF = 2'd1;
   localparam logic [1:0] MODE_HOLD = 2'd2;

   localparam int WR = W + 2;
   localparam int WD = W + 3;

   localparam logic signed [WD-1:0] SLEW_C = WD'(SLEW_MAX);
   localparam logic signed [WD-1:0] MAX_C  = WD'(OUT_MAX);
   localparam logic signed [WD-1:0] MIN_C  = WD'(OUT_MIN);

   logic [1:0]           state_q, state_d;
   logic [1:0]           mode_q, mode_d;
   logic signed [W-1:0]  in_q, in_d;
   logic signed [W-1:0]  prev_old_q, prev_old_d;
   logic signed [W-1:0]  prev_in_q, prev_in_d;
   logic signed [WR-1:0] raw_q, raw_d;
   logic signed [W-1:0]  out_vel_q, out_vel_d;
   logic                 out_valid_q, out_valid_d;
   logic                 sat_hi_q, sat_hi_d;
   logic                 sat_lo_q, sat_lo_d;
   logic                 slew_lim_q, slew_lim_d;

   logic                 accept;
   logic signed [WR-1:0] out_x, in_x, prev_x;
   logic signed [WD-1:0] out_w, raw_w, delta, lim;

   assign in_ready = (state_q == IDLE);
   assign accept   = in_valid & in_ready & ~clear;

   assign out_x  = {{2{out_vel_q[W-1]}}, out_vel_q};
   assign in_x   = {{2{in_q[W-1]}}, in_q};
   assign prev_x = {{2{prev_old_q[W-1]}}, prev_old_q};
   assign out_w  = {{3{out_vel_q[W-1]}}, out_vel_q};
   assign raw_w  = {raw_q[WR-1], raw_q};
   assign delta  = raw_w - out_w;

   always_comb begin
      lim        = raw_w;
      slew_lim_d = 1'b0;
      if ((SLEW_MAX != 0) && ((delta > SLEW_C) || (delta < -SLEW_C))) begin
         lim        = delta[WD-1] ? (out_w - SLEW_C) : (out_w + SLEW_C);
         slew_lim_d = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      in_d        = in_q;
      prev_old_d  = prev_old_q;
      prev_in_d   = prev_in_q;
      raw_d       = raw_q;
      out_vel_d   = out_vel_q;
      out_valid_d = 1'b0;
      sat_hi_d    = sat_hi_q;
      sat_lo_d    = sat_lo_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               in_d       = in_vel;
               mode_d     = mode;
               prev_old_d = prev_in_q;
               prev_in_d  = in_vel;
               state_d    = CALC;
            end
         end
         CALC: begin
            case (mode_q)
               MODE_ACC:  raw_d = out_x + in_x;
               MODE_DIFF: raw_d = in_x - prev_x;
               MODE_HOLD: raw_d = out_x;
               default:   raw_d = in_x;
            endcase
            state_d = LIMIT;
         end
         LIMIT: begin
            out_valid_d = 1'b1;
            sat_hi_d    = 1'b0;
            sat_lo_d    = 1'b0;
            if (lim > MAX_C) begin
               out_vel_d = MAX_C[W-1:0];
               sat_hi_d  = 1'b1;
            end else if (lim < MIN_C) begin
               out_vel_d = MIN_C[W-1:0];
               sat_lo_d  = 1'b1;
            end else begin
               out_vel_d = lim[W-1:0];
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // clear overrides everything, including an in-flight sample
      if (clear) begin
         state_d     = IDLE;
         prev_in_d   = '0;
         out_vel_d   = '0;
         out_valid_d = 1'b0;
         sat_hi_d    = 1'b0;
         sat_lo_d    = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state_q     <= IDLE;
         mode_q      <= 2'd0;
         in_q        <= '0;
         prev_old_q  <= '0;
         prev_in_q   <= '0;
         raw_q       <= '0;
         out_vel_q   <= '0;
         out_valid_q <= 1'b0;
         sat_hi_q    <= 1'b0;
         sat_lo_q    <= 1'b0;
         slew_lim_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         in_q        <= in_d;
         prev_old_q  <= prev_old_d;
         prev_in_q   <= prev_in_d;
         raw_q       <= raw_d;
         out_vel_q   <= out_vel_d;
         out_valid_q <= out_valid_d;
         sat_hi_q    <= sat_hi_d;
         sat_lo_q    <= sat_lo_d;
         if (clear) begin
            slew_lim_q <= 1'b0;
         end else if (state_q == LIMIT) begin
            slew_lim_q <= slew_lim_d;
         end
      end
   end

   assign out_vel   = out_vel_q;
   assign out_valid = out_valid_q;
   assign sat_hi    = sat_hi_q;
   assign sat_lo    = sat_lo_q;
   assign slew_lim  = slew_lim_q;

endmodule

// File: tb/tb_pid_vel_integrator.sv
// Bench for pid_vel_integrator: instance a uses default parameters, instance b has SLEW_MAX = 16.
module tb_pid_vel_integrator;

   logic              clk = 1'b0;
   logic              rstn;
   logic signed [8:0] in_vel;
   logic              in_valid;
   logic [1:0]        mode;
   logic              clear;

   logic              ready_a, ready_b;
   logic signed [8:0] out_a, out_b;
   logic              ov_a, ov_b;
   logic              hi_a, lo_a, sl_a, hi_b, lo_b, sl_b;

   int n_tests = 0;
   int n_fail  = 0;

   int m_out[2];
   int m_prev[2];
   bit m_hi[2], m_lo[2], m_sl[2];

   always #5 clk = ~clk;

   pid_vel_integrator #(.W(9)) u_a (
      .CLK(clk), .RSTN(rstn), .in_vel(in_vel), .in_valid(in_valid), .in_ready(ready_a),
      .mode(mode), .clear(clear), .out_vel(out_a), .out_valid(ov_a),
      .sat_hi(hi_a), .sat_lo(lo_a), .slew_lim(sl_a)
   );

   pid_vel_integrator #(.W(9), .SLEW_MAX(16)) u_b (
      .CLK(clk), .RSTN(rstn), .in_vel(in_vel), .in_valid(in_valid), .in_ready(ready_b),
      .mode(mode), .clear(clear), .out_vel(out_b), .out_valid(ov_b),
      .sat_hi(hi_b), .sat_lo(lo_b), .slew_lim(sl_b)
   );

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         m_out[k] = 0; m_prev[k] = 0; m_hi[k] = 0; m_lo[k] = 0; m_sl[k] = 0;
      end
   endtask

   // Plain-integer reference: raw value by mode, then slew clamp, then saturation.
   task automatic model_step(input int vin, input int md);
      for (int k = 0; k < 2; k++) begin
         int slew, raw, delta, lim;
         slew = (k == 0) ? 0 : 16;
         case (md)
            0: raw = m_out[k] + vin;
            1: raw = vin - m_prev[k];
            2: raw = m_out[k];
            default: raw = vin;
         endcase
         m_prev[k] = vin;
         delta = raw - m_out[k];
         lim = raw;
         m_sl[k] = 0;
         if (slew != 0 && (delta > slew || delta < -slew)) begin
            lim = (delta > 0) ? m_out[k] + slew : m_out[k] - slew;
            m_sl[k] = 1;
         end
         m_hi[k] = (lim > 255);
         m_lo[k] = (lim < -255);
         m_out[k] = m_hi[k] ? 255 : (m_lo[k] ? -255 : lim);
      end
   endtask

   // Drives one sample at a negedge with in_ready high; returns out_valid seen after edges N..N+2.
   task automatic send(input int v, input int md, output logic [2:0] ov, output logic rdy);
      in_vel = 9'(v); mode = 2'(md); in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      ov[0] = ov_a;
      @(posedge clk); @(negedge clk);
      ov[1] = ov_a;
      @(posedge clk); @(negedge clk);
      ov[2] = ov_a & ov_b;
      rdy = ready_a;
      model_step(v, md);
   endtask

   task automatic do_clear();
      in_valid = 1'b1; in_vel = 9'sd100; mode = 2'd3; clear = 1'b1;
      @(posedge clk); @(negedge clk);
      clear = 1'b0; in_valid = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      rstn = 1'b0; clear = 1'b0; in_valid = 1'b0; in_vel = '0; mode = 2'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      model_clear();
      @(posedge clk); @(negedge clk);
      n_tests++;
      if ({ov_a, hi_a, lo_a, sl_a} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_flags got %b exp 0000", {ov_a, hi_a, lo_a, sl_a});
      end
      n_tests++;
      if (out_a !== 9'sd0) begin n_fail++; $display("FAIL reset_out got %0d exp 0", out_a); end
      n_tests++;
      if (ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", ready_a); end
      // reset during CALC drops the sample
      in_valid = 1'b1; in_vel = 9'sd80; mode = 2'd3;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0; rstn = 1'b0;
      @(posedge clk); @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (ov_a !== 1'b0 || out_a !== 9'sd0) begin
         n_fail++; $display("FAIL reset_abort got ov=%b out=%0d exp ov=0 out=0", ov_a, out_a);
      end
   endtask

   task automatic test_back_to_back();
      int exp_v;
      do_clear();
      in_valid = 1'b1; in_vel = 9'sd50; mode = 2'd0;
      for (int c = 0; c < 9; c++) begin
         @(posedge clk); @(negedge clk);
         n_tests++;
         if (ov_a !== ((c % 3) == 2)) begin
            n_fail++; $display("FAIL b2b_valid edge %0d got %b exp %b", c, ov_a, (c % 3) == 2);
         end
         n_tests++;
         if (ready_a !== ((c % 3) == 2)) begin
            n_fail++; $display("FAIL b2b_ready edge %0d got %b exp %b", c, ready_a, (c % 3) == 2);
         end
         if ((c % 3) == 2) begin
            exp_v = 50 * (c / 3 + 1);
            n_tests++;
            if (out_a !== 9'(exp_v) || {hi_a, lo_a, sl_a} !== 3'b000) begin
               n_fail++;
               $display("FAIL b2b_out edge %0d got %0d/%b exp %0d/000", c, out_a,
                        {hi_a, lo_a, sl_a}, exp_v);
            end
         end
      end
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) model_step(50, 0);
   endtask

   task automatic test_saturation();
      logic [2:0] ov;
      logic       rdy;
      do_clear();
      send(250, 3, ov, rdy);
      send(20, 0, ov, rdy);
      n_tests++;
      if (out_a !== 9'sd255 || {hi_a, lo_a, sl_a} !== 3'b100 || ov !== 3'b100) begin
         n_fail++; $display("FAIL sat_hi got %0d/%b exp 255/100", out_a, {hi_a, lo_a, sl_a});
      end
      send(-256, 0, ov, rdy);
      n_tests++;
      if (out_a !== -9'sd1 || {hi_a, lo_a, sl_a} !== 3'b000) begin
         n_fail++; $display("FAIL sat_release got %0d/%b exp -1/000", out_a, {hi_a, lo_a, sl_a});
      end
      send(-250, 3, ov, rdy);
      send(-20, 0, ov, rdy);
      n_tests++;
      if (out_a !== -9'sd255 || {hi_a, lo_a, sl_a} !== 3'b010) begin
         n_fail++; $display("FAIL sat_lo got %0d/%b exp -255/010", out_a, {hi_a, lo_a, sl_a});
      end
   endtask

   task automatic test_difference();
      logic [2:0] ov;
      logic       rdy;
      do_clear();
      send(10, 3, ov, rdy);
      send(-30, 1, ov, rdy);
      n_tests++;
      if (out_a !== -9'sd40) begin n_fail++; $display("FAIL diff1 got %0d exp -40", out_a); end
      send(-30, 1, ov, rdy);
      n_tests++;
      if (out_a !== 9'sd0) begin n_fail++; $display("FAIL diff2 got %0d exp 0", out_a); end
   endtask

   task automatic test_slew();
      logic [2:0] ov;
      logic       rdy;
      do_clear();
      for (int i = 1; i <= 3; i++) begin
         send(100, 3, ov, rdy);
         n_tests++;
         if (out_b !== 9'(16 * i) || sl_b !== 1'b1 || ov !== 3'b100) begin
            n_fail++; $display("FAIL slew_step%0d got %0d sl=%b exp %0d sl=1", i, out_b, sl_b, 16 * i);
         end
      end
      send(40, 3, ov, rdy);
      n_tests++;
      if (out_b !== 9'sd40 || sl_b !== 1'b0) begin
         n_fail++; $display("FAIL slew_settle got %0d sl=%b exp 40 sl=0", out_b, sl_b);
      end
   endtask

   task automatic test_clear();
      logic [2:0] ov;
      logic       rdy;
      do_clear();
      n_tests++;
      if (ready_a !== 1'b1) begin
         n_fail++; $display("FAIL clear_no_accept ready got %b exp 1", ready_a);
      end
      send(60, 3, ov, rdy);
      in_valid = 1'b1; in_vel = 9'sd80; mode = 2'd0;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0; clear = 1'b1;
      @(posedge clk); @(negedge clk);
      clear = 1'b0;
      model_clear();
      n_tests++;
      if (ready_a !== 1'b1 || out_a !== 9'sd0) begin
         n_fail++; $display("FAIL clear_mid got ready=%b out=%0d exp ready=1 out=0", ready_a, out_a);
      end
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (ov_a !== 1'b0) begin n_fail++; $display("FAIL clear_drop valid got %b exp 0", ov_a); end
      send(77, 2, ov, rdy);
      n_tests++;
      if (out_a !== 9'sd0 || ov !== 3'b100) begin
         n_fail++; $display("FAIL clear_hold got %0d ov=%b exp 0 ov=100", out_a, ov);
      end
      do_clear();
      send(5, 1, ov, rdy);
      n_tests++;
      if (out_a !== 9'sd5) begin n_fail++; $display("FAIL clear_prev got %0d exp 5", out_a); end
   endtask

   task automatic test_random();
      logic [2:0] ov;
      logic       rdy;
      int         v, md;
      do_clear();
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 15) == 0) do_clear();
         repeat ($urandom_range(0, 2)) @(negedge clk);
         v  = int'($urandom_range(0, 511)) - 256;
         md = int'($urandom_range(0, 3));
         send(v, md, ov, rdy);
         n_tests++;
         if (ov !== 3'b100 || rdy !== 1'b1) begin
            n_fail++; $display("FAIL rnd%0d_timing got ov=%b rdy=%b exp 100/1", i, ov, rdy);
         end
         n_tests++;
         if (out_a !== 9'(m_out[0]) || {hi_a, lo_a, sl_a} !== {m_hi[0], m_lo[0], m_sl[0]}) begin
            n_fail++;
            $display("FAIL rnd%0d_a v=%0d m=%0d got %0d/%b exp %0d/%b", i, v, md, out_a,
                     {hi_a, lo_a, sl_a}, m_out[0], {m_hi[0], m_lo[0], m_sl[0]});
         end
         n_tests++;
         if (out_b !== 9'(m_out[1]) || {hi_b, lo_b, sl_b} !== {m_hi[1], m_lo[1], m_sl[1]}) begin
            n_fail++;
            $display("FAIL rnd%0d_b v=%0d m=%0d got %0d/%b exp %0d/%b", i, v, md, out_b,
                     {hi_b, lo_b, sl_b}, m_out[1], {m_hi[1], m_lo[1], m_sl[1]});
         end
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_saturation();
      test_difference();
      test_slew();
      test_clear();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
